// File: rtl/enc_pkg.sv
// Shared definitions for the registered priority encoder.
//   enc_state_t : offer FSM states (IDLE = nothing offered, OFFER = y/valid held)
//   N_REQ       : number of request lines
//   W_CODE      : width of the encoded index
package enc_pkg;

    localparam int N_REQ  = 4;
    localparam int W_CODE = $clog2(N_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_t;

endpackage

// File: rtl/prio_encoder_if.sv
// Request/offer bundle for prio_encoder.
//   e, d   : capture enable and request lines (producer -> encoder)
//   y      : encoded index being offered (encoder -> consumer)
//   valid  : y holds an offer; ready: consumer accepts it this cycle.
//            A transfer ("fire") happens on a rising clock edge where
//            valid & ready are both high; y is held while valid & ~ready.
//   ovf    : one-cycle pulse, a request hit an already-pending bit
//   busy   : pending requests exist or an offer is outstanding
// master : the side that drives requests and ready (e.g. testbench)
// slave  : the encoder itself
import enc_pkg::*;

interface prio_encoder_if #(
    parameter int N = N_REQ
);
    localparam int W = $clog2(N);

    logic         e;
    logic [N-1:0] d;
    logic         ready;
    logic [W-1:0] y;
    logic         valid;
    logic         ovf;
    logic         busy;

    modport master (
        output e, d, ready,
        input  y, valid, ovf, busy
    );

    modport slave (
        input  e, d, ready,
        output y, valid, ovf, busy
    );

endinterface

// File: rtl/prio_enc.sv
// Combinational highest-index-wins priority encoder.
//   vec : input request vector
//   idx : index of the highest set bit (0 when vec is zero)
//   any : vec is non-zero
import enc_pkg::*;

module prio_enc #(
    parameter  int N = N_REQ,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: a later (higher) set bit overwrites a lower one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encoder.sv
// Registered 4-to-2 priority encoder with request latching.
// Requests on d (gated by e) are latched into pend; the highest pending
// index is offered on y/valid and cleared from pend when the consumer
// accepts it. A new request always wins over a same-cycle clear.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : prio_encoder_if slave (e, d, ready in; y, valid, ovf, busy out)
//   dbg_state : current FSM state
//   dbg_pend  : pending request register
import enc_pkg::*;

module prio_encoder #(
    parameter  int N = N_REQ,
    localparam int W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    prio_encoder_if.slave     bus,
    output enc_state_t        dbg_state,
    output logic [N-1:0]      dbg_pend
);

    enc_state_t   state, state_next;
    logic [N-1:0] pend;
    logic [N-1:0] clr;
    logic [N-1:0] cap;
    logic [W-1:0] y_reg, y_next;
    logic         ovf_reg;
    logic [W-1:0] top_idx;
    logic         top_any;
    logic         fire;

    prio_enc #(.N(N)) u_prio_enc (
        .vec (pend),
        .idx (top_idx),
        .any (top_any)
    );

    assign cap  = bus.e ? bus.d : '0;
    assign fire = (state == OFFER) && bus.ready;
    // One-hot clear of the offered index, only on an accepted offer.
    assign clr  = fire ? (N'(1) << y_reg) : '0;

    always_comb begin
        state_next = state;
        y_next     = y_reg;
        case (state)
            IDLE: begin
                if (top_any) begin
                    y_next     = top_idx;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                // y is frozen here; later higher-priority arrivals wait.
                if (bus.ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            y_reg   <= '0;
            pend    <= '0;
            ovf_reg <= 1'b0;
        end else begin
            state   <= state_next;
            y_reg   <= y_next;
            // Set term is ORed last so a same-cycle capture beats the clear.
            pend    <= (pend & ~clr) | cap;
            // Lost request: captured into a bit that is pending and staying.
            ovf_reg <= |(cap & pend & ~clr);
        end
    end

    assign bus.y     = y_reg;
    assign bus.valid = (state == OFFER);
    assign bus.ovf   = ovf_reg;
    assign bus.busy  = (|pend) | (state == OFFER);

    assign dbg_state = state;
    assign dbg_pend  = pend;

endmodule

// File: tb/tb_prio_encoder.sv
// Directed testbench for prio_encoder.
import enc_pkg::*;

module tb_prio_encoder;

    localparam int N = N_REQ;

    logic       clk;
    logic       rst;
    enc_state_t dbg_state;
    logic [N-1:0] dbg_pend;

    int checks = 0;
    int errors = 0;

    prio_encoder_if #(.N(N)) bus ();

    prio_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_pend  (dbg_pend)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [N-1:0] d, input logic ready);
        bus.e     = e;
        bus.d     = d;
        bus.ready = ready;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic valid, input logic [1:0] y,
                             input logic [N-1:0] pend, input logic ovf, input logic busy);
        check({tag, ".valid"}, 32'(bus.valid), 32'(valid));
        if (valid) check({tag, ".y"}, 32'(bus.y), 32'(y));
        check({tag, ".pend"},  32'(dbg_pend),  32'(pend));
        check({tag, ".ovf"},   32'(bus.ovf),   32'(ovf));
        check({tag, ".busy"},  32'(bus.busy),  32'(busy));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b0);
        tick();
        tick();
        check("rst.state", 32'(dbg_state), 32'(IDLE));
        check("rst.y", 32'(bus.y), 32'd0);
        check_out("rst", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_out("idle", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // ---- single request ----
        drive(1'b1, 4'b0100, 1'b1);
        tick();
        check_out("single.cap", 1'b0, 2'd0, 4'b0100, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b1);
        tick();
        check_out("single.offer", 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1);
        tick();
        check_out("single.fired", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        tick();
        check_out("single.quiet", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // ---- priority / no preemption ----
        drive(1'b1, 4'b0001, 1'b0);
        tick();
        check_out("nopre.cap", 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        check_out("nopre.offer0", 1'b1, 2'd0, 4'b0001, 1'b0, 1'b1);
        drive(1'b1, 4'b1000, 1'b0);
        tick();
        check_out("nopre.hold1", 1'b1, 2'd0, 4'b1001, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        check_out("nopre.hold2", 1'b1, 2'd0, 4'b1001, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b1);
        tick();
        check_out("nopre.fire0", 1'b0, 2'd0, 4'b1000, 1'b0, 1'b1);
        tick();
        check_out("nopre.offer3", 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1);
        tick();
        check_out("nopre.fire3", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // ---- burst drain 3,2,1,0 ----
        drive(1'b1, 4'b1111, 1'b1);
        tick();
        check_out("burst.cap", 1'b0, 2'd0, 4'b1111, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b1);
        tick();
        check_out("burst.y3", 1'b1, 2'd3, 4'b1111, 1'b0, 1'b1);
        tick();
        check_out("burst.gap3", 1'b0, 2'd0, 4'b0111, 1'b0, 1'b1);
        tick();
        check_out("burst.y2", 1'b1, 2'd2, 4'b0111, 1'b0, 1'b1);
        tick();
        check_out("burst.gap2", 1'b0, 2'd0, 4'b0011, 1'b0, 1'b1);
        tick();
        check_out("burst.y1", 1'b1, 2'd1, 4'b0011, 1'b0, 1'b1);
        tick();
        check_out("burst.gap1", 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1);
        tick();
        check_out("burst.y0", 1'b1, 2'd0, 4'b0001, 1'b0, 1'b1);
        tick();
        check_out("burst.done", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // ---- set wins over clear ----
        drive(1'b1, 4'b0010, 1'b0);
        tick();
        check_out("setwin.cap", 1'b0, 2'd0, 4'b0010, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        check_out("setwin.offer", 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1);
        drive(1'b1, 4'b0010, 1'b1);
        tick();
        check_out("setwin.fire", 1'b0, 2'd0, 4'b0010, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        check_out("setwin.reoffer", 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b1);
        tick();
        check_out("setwin.fire2", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // ---- overflow pulse ----
        drive(1'b1, 4'b0100, 1'b0);
        tick();
        check_out("ovf.cap", 1'b0, 2'd0, 4'b0100, 1'b0, 1'b1);
        tick();
        check_out("ovf.pulse", 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1);
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        check_out("ovf.clear", 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b1);
        tick();
        check_out("ovf.fire", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // ---- enable gating ----
        drive(1'b0, 4'b1111, 1'b0);
        tick();
        check_out("gate.blocked", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 4'b0001, 1'b0);
        tick();
        check_out("gate.cap", 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1);
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        check_out("gate.offer", 1'b1, 2'd0, 4'b0001, 1'b0, 1'b1);
        drive(1'b0, 4'b1111, 1'b0);
        tick();
        check_out("gate.keep", 1'b1, 2'd0, 4'b0001, 1'b0, 1'b1);
        drive(1'b0, 4'b1111, 1'b1);
        tick();
        check_out("gate.fire", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        tick();
        check_out("gate.none", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // ---- asynchronous reset mid-offer ----
        drive(1'b1, 4'b1010, 1'b0);
        tick();
        check_out("arst.cap", 1'b0, 2'd0, 4'b1010, 1'b0, 1'b1);
        tick();
        check_out("arst.offer", 1'b1, 2'd3, 4'b1010, 1'b1, 1'b1);
        drive(1'b1, 4'b0000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.state", 32'(dbg_state), 32'(IDLE));
        check("arst.y", 32'(bus.y), 32'd0);
        check_out("arst.now", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_out("arst.after1", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        tick();
        check_out("arst.after2", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, 1'b0);
        tick();
        drive(1'b1, 4'b0000, 1'b0);
        tick();
        check_out("arst.newreq", 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_encoder.md
# prio_encoder

Registered 4-to-2 priority encoder with request latching and a valid/ready output handshake. It is the inverse of the team's 2-to-4 enable decoder: it takes individual request lines, remembers them, and returns the encoded index of the highest-priority pending request. Downstream logic acknowledges each index, and that acknowledgement clears the matching pending bit. It sits between discrete event/request sources and a consumer that services one index at a time.

## Interface
- `N`, default 4: number of request lines (this spec and its test plan cover N = 4).
- `W`, default 2: code width, equal to $clog2(N); it is derived and not overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `e` input 1: capture enable; when low, `d` is ignored.
- `d` input N: request lines, sampled each cycle; bit i requests index i.
- `ready` input 1: consumer accepts `y` this cycle.
- `y` output W: encoded index of the offered request.
- `valid` output 1: `y` holds a valid offer.
- `ovf` output 1: one-cycle pulse when a request is lost.
- `busy` output 1: high when `pend` is non-zero or `valid` is high.

## Operation
- `pend[N-1:0]` register. Each edge: `pend <= (pend & ~clr) | (e ? d : 0)`.
  - `clr` is the one-hot decode of `y`, and is driven only on fire (`valid & ready`).
  - Set wins: if `d[i]` arrives in the same cycle that bit i is cleared, `pend[i]` stays 1.
- Priority is fixed, with the highest index winning (bit 3 > 2 > 1 > 0).
- Two-state FSM (`IDLE`, `OFFER`):
  - `IDLE`: `valid` = 0. If `pend` (registered) is non-zero, load `y` with the highest set index of `pend`, then go to `OFFER`.
  - `OFFER`: `valid` = 1 and `y` is held stable. On `ready` = 1, fire (clear `pend[y]`) and return to `IDLE`. Without `ready`, stay in `OFFER`.
- No preemption: a higher-priority arrival during `OFFER` does not change `y`; it is offered after the current fire.
- `ovf`: registered pulse, set the cycle after `e & d[i] & pend[i] & ~clr[i]` for any i. It is not sticky.
- `e` low:
  - New captures are blocked.
  - Existing `pend` bits are not flushed.
  - An in-flight offer completes normally.
- `busy` is combinational from registers: `|pend | valid`.

## Timing
- Reset values: `pend` = 0, state `IDLE`, `y` = 0, `valid` = 0, `ovf` = 0, `busy` = 0. Reset clears these asynchronously, including mid-offer, so `valid` drops immediately without waiting for an edge.
- Latency:
  - `d[i]` sampled at edge k sets `pend[i]` at k.
  - `valid` and `y` appear at edge k+1.
- Throughput: at most one fire every 2 cycles (`OFFER` -> `IDLE` -> `OFFER`).
- Fire at edge m clears `pend[y]` at m. The next offer, if `pend` is still non-zero, appears at edge m+1.
- `y` must not change while `valid` = 1 and `ready` = 0.
- `ready` while `valid` = 0 has no effect.
- With all N requests pending and `ready` held high, indices appear as 3, 2, 1, 0 on `valid` cycles spaced 2 apart.

## Structure
- Shared package `enc_pkg` holds:
  - the state enum `enc_state_t` {`IDLE`, `OFFER`};
  - the localparams `N_REQ` = 4 and `W_CODE` = $clog2(N_REQ).
- One combinational sub-module, `prio_enc`: takes an N-bit vector and returns the W-bit highest-set index plus an `any` flag. The FSM and the `pend` register live in `prio_encoder`.
- The `clr` one-hot decode is inline and does not reuse the decoder block.

## Test plan
- Reset and idle: assert `rst` mid-offer with `pend` = 4'b1010 -> `valid`, `pend`, `ovf` and `busy` all go to 0 immediately; no offer follows until a new `d`.
- Single request: `e` = 1, `d` = 4'b0100 for one cycle, `ready` = 1 -> `valid` high 2 edges later with `y` = 2, fires, `busy` = 0 one cycle later.
- Priority and no-preempt: `d` = 4'b0001, then hold `ready` = 0 and inject `d` = 4'b1000 -> `y` stays 0 until `ready`; the next offer is `y` = 3.
- Burst drain: `d` = 4'b1111 in one cycle, `ready` = 1 -> `y` sequence 3, 2, 1, 0, each `valid` cycle spaced 2 apart, then `busy` = 0.
- Set-wins/overflow:
  - Re-assert `d[1]` on the fire cycle of `y` = 1 -> `pend[1]` remains 1 and index 1 is re-offered.
  - Assert `d[2]` while `pend[2]` = 1 and it is not being cleared -> `ovf` pulses once, 1 cycle later.
- Enable gating: `e` = 0 with `d` = 4'b1111 -> `pend` is unchanged and no `valid`. An in-flight offer during `e` = 0 still fires on `ready`.
